// File: rtl/cpu_pkg.sv
// cpu_pkg -- definitions shared by the cpu core, hazard logic and the
// memory access unit.
//   ADDR_W_DEFAULT : default data-memory word-address width
//   opcode_t       : 5-bit instruction opcode
//   OP_*           : opcodes the memory stage cares about
//   is_mem_op      : true for opcodes that go out on the data-memory bus
//   writes_reg     : false for opcodes that never write the register file
package cpu_pkg;

    localparam int ADDR_W_DEFAULT = 17;

    typedef logic [4:0] opcode_t;

    localparam opcode_t OP_LW     = 5'd21;
    localparam opcode_t OP_SW     = 5'd22;
    localparam opcode_t OP_BT     = 5'd23;
    localparam opcode_t OP_BF     = 5'd24;
    localparam opcode_t OP_LI     = 5'd27;
    localparam opcode_t OP_LUI    = 5'd28;
    localparam opcode_t OP_EBREAK = 5'd31;

    function automatic logic is_mem_op(input opcode_t op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

    function automatic logic writes_reg(input opcode_t op);
        return !((op == OP_SW) || (op == OP_BT) || (op == OP_BF) || (op == OP_EBREAK));
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if -- data-memory request bus.
//   mem_req / mem_we / mem_addr / mem_wdata : request, driven by the master
//   mem_ready / mem_rdata                   : acknowledge and load data, driven
//                                             by the memory in the same cycle
// Modports: master (memory access unit), slave (data memory).
interface mem_access_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_access_unit_access_timer.sv
// access_timer -- counts unhalted cycles spent waiting on the data memory and
// flags the cycle on which the wait limit is reached.
//   clk, reset : clock, asynchronous active-high reset
//   busy       : the access unit is waiting for mem_ready (counter clears otherwise)
//   count_en   : count this cycle (low while halted, so the count freezes)
//   expired    : this is the TIMEOUT_CYCLES-th waiting cycle; abort at the next edge
module access_timer
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic count_en,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (!busy) begin
            count_reg <= '0;
        end else if (count_en) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // count_reg holds the number of waiting cycles already completed, so the
    // current cycle is the last permitted one when it equals TIMEOUT_CYCLES-1.
    assign expired = busy && count_en && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit -- memory stage of the pipeline. Loads and stores are sent to
// the data memory through a three-state FSM (IDLE -> BUSY -> DONE) while the
// upstream pipeline is stalled; all other opcodes pass through to writeback
// in one registered cycle.
//   clk, reset         : clock, asynchronous active-high reset
//   halted             : debug freeze, holds all state and outputs
//   in_valid/in_op/in_rd/in_addr/in_data : instruction from the execute stage
//   stall              : hold upstream (combinational)
//   wb_en/wb_rd/wb_data: registered register-file writeback
//   mem                : data-memory bus (master side)
//   err                : sticky access-timeout flag
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that wait longer
// than TIMEOUT_CYCLES unhalted cycles; otherwise BUSY waits forever, err = 0.
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    halted,
    input  logic                    in_valid,
    input  opcode_t                 in_op,
    input  logic [4:0]              in_rd,
    input  logic [ADDR_W-1:0]       in_addr,
    input  logic [31:0]             in_data,
    output logic                    stall,
    output logic                    wb_en,
    output logic [4:0]              wb_rd,
    output logic [31:0]             wb_data,
    mem_access_unit_if.master       mem,
    output logic                    err
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]        state_reg;
    logic              mem_req_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;
    logic              wb_en_reg;
    logic [4:0]        wb_rd_reg;
    logic [31:0]       wb_data_reg;
    logic              timeout_expired;
    logic [31:0]       addr_ext;
    logic [31:0]       pass_data;

    // Immediate forms: LI zero-extends the address field, LUI places its low
    // 15 bits in the top of the word.
    assign addr_ext = 32'(in_addr);

    always_comb begin
        pass_data = in_data;
        case (in_op)
            OP_LI:   pass_data = addr_ext;
            OP_LUI:  pass_data = {addr_ext[14:0], 17'b0};
            default: pass_data = in_data;
        endcase
    end

    assign stall = ((state_reg == ST_IDLE) && in_valid && is_mem_op(in_op))
                 || (state_reg == ST_BUSY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            wb_en_reg     <= 1'b0;
            wb_rd_reg     <= '0;
            wb_data_reg   <= '0;
        end else if (!halted) begin
            case (state_reg)
                ST_IDLE: begin
                    wb_rd_reg <= in_rd;
                    if (in_valid && is_mem_op(in_op)) begin
                        state_reg     <= ST_BUSY;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= (in_op == OP_SW);
                        mem_addr_reg  <= in_addr;
                        mem_wdata_reg <= in_data;
                        wb_en_reg     <= 1'b0;
                    end else begin
                        wb_en_reg   <= in_valid && writes_reg(in_op);
                        wb_data_reg <= pass_data;
                    end
                end
                ST_BUSY: begin
                    // in_rd is still the accepted instruction's: upstream is stalled.
                    if (mem.mem_ready) begin
                        state_reg   <= ST_DONE;
                        mem_req_reg <= 1'b0;
                        wb_en_reg   <= !mem_we_reg;
                        wb_rd_reg   <= in_rd;
                        wb_data_reg <= mem.mem_rdata;
                    end else if (timeout_expired) begin
                        state_reg   <= ST_DONE;
                        mem_req_reg <= 1'b0;
                        wb_en_reg   <= !mem_we_reg;
                        wb_rd_reg   <= in_rd;
                        wb_data_reg <= '0;
                    end
                end
                ST_DONE: begin
                    // Upstream advances this cycle; the writeback slot is a bubble.
                    state_reg <= ST_IDLE;
                    wb_en_reg <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic err_reg;

    access_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_access_timer (
        .clk      (clk),
        .reset    (reset),
        .busy     (state_reg == ST_BUSY),
        .count_en (!halted),
        .expired  (timeout_expired)
    );

    // A completion in the same cycle as expiry wins, so no error is flagged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (!halted && (state_reg == ST_BUSY) && !mem.mem_ready && timeout_expired) begin
            err_reg <= 1'b1;
        end
    end

    assign err = err_reg;
`else
    // Without the timer TIMEOUT_CYCLES has no effect.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_expired    = 1'b0;
    assign err                = 1'b0;
`endif

    assign mem.mem_req   = mem_req_reg;
    assign mem.mem_we    = mem_we_reg;
    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign wb_en         = wb_en_reg;
    assign wb_rd         = wb_rd_reg;
    assign wb_data       = wb_data_reg;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit -- directed and randomized bench for mem_access_unit.
// Inputs change 1 time unit after each rising edge; outputs are sampled there.
// Build with MEM_TIMEOUT_EN defined to exercise the access timeout (limit 8).
module tb_mem_access_unit;
    import cpu_pkg::*;

    localparam int AW = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          halted;
    logic          in_valid;
    logic [4:0]    in_op;
    logic [4:0]    in_rd;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_data;
    logic          stall;
    logic          wb_en;
    logic [4:0]    wb_rd;
    logic [31:0]   wb_data;
    logic          err;

    int checks = 0;
    int errors = 0;

    mem_access_unit_if #(.ADDR_W(AW)) mem_bus ();

    mem_access_unit #(
        .ADDR_W         (AW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .halted   (halted),
        .in_valid (in_valid),
        .in_op    (in_op),
        .in_rd    (in_rd),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .stall    (stall),
        .wb_en    (wb_en),
        .wb_rd    (wb_rd),
        .wb_data  (wb_data),
        .mem      (mem_bus),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rules for non-memory instructions.
    function automatic logic model_writes(input logic [4:0] op);
        return !(op inside {OP_SW, OP_BT, OP_BF, OP_EBREAK});
    endfunction

    function automatic logic [31:0] model_wb(input logic [4:0] op, input logic [AW-1:0] a,
                                             input logic [31:0] d);
        logic [31:0] r;
        if (op == OP_LI)       r = {15'b0, a};
        else if (op == OP_LUI) r = {a[14:0], 17'b0};
        else                   r = d;
        return r;
    endfunction

    // One pass-through instruction (or an invalid slot): never stalls,
    // result visible one cycle later.
    task automatic alu_txn(input logic valid, input logic [4:0] op, input logic [4:0] rd,
                           input logic [AW-1:0] addr, input logic [31:0] data);
        logic exp_en;
        in_valid = valid; in_op = op; in_rd = rd; in_addr = addr; in_data = data;
        exp_en = valid && model_writes(op);
        $display("txn alu: valid=%0b op=%0d rd=%0d addr=0x%0h data=0x%0h", valid, op, rd, addr, data);
        #1;
        check("alu_stall", stall, 1'b0);
        tick();
        check("alu_wb_en", wb_en, exp_en);
        check("alu_req", mem_bus.mem_req, 1'b0);
        if (exp_en) begin
            check("alu_wb_data", wb_data, model_wb(op, addr, data));
            check("alu_wb_rd", wb_rd, rd);
        end
    endtask

    // One load or store; the memory acknowledges in request cycle k (k >= 1).
    task automatic mem_txn(input logic is_load, input logic [4:0] rd, input logic [AW-1:0] addr,
                           input logic [31:0] data, input int k, input logic [31:0] rdata);
        in_valid = 1'b1; in_op = is_load ? OP_LW : OP_SW; in_rd = rd; in_addr = addr; in_data = data;
        mem_bus.mem_ready = 1'b0;
        $display("txn %s: rd=%0d addr=0x%0h data=0x%0h ready_cycle=%0d rdata=0x%0h",
                 is_load ? "lw" : "sw", rd, addr, data, k, rdata);
        #1;
        check("accept_stall", stall, 1'b1);
        for (int i = 1; i <= k; i++) begin
            tick();
            check("busy_req", mem_bus.mem_req, 1'b1);
            check("busy_stall", stall, 1'b1);
            check("busy_we", mem_bus.mem_we, !is_load);
            check("busy_addr", 32'(mem_bus.mem_addr), 32'(addr));
            if (!is_load) check("busy_wdata", mem_bus.mem_wdata, data);
            check("busy_wb_en", wb_en, 1'b0);
            if (i == k) begin
                mem_bus.mem_ready = 1'b1;
                mem_bus.mem_rdata = rdata;
            end else begin
                mem_bus.mem_rdata = $urandom;
            end
        end
        tick();
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = $urandom;
        #1;
        check("done_stall", stall, 1'b0);
        check("done_req", mem_bus.mem_req, 1'b0);
        check("done_wb_en", wb_en, is_load);
        if (is_load) begin
            check("done_wb_data", wb_data, rdata);
            check("done_wb_rd", wb_rd, rd);
        end
        in_valid = 1'b0;
        tick();
        check("bubble_wb_en", wb_en, 1'b0);
    endtask

    initial begin
        logic [4:0]  ops [9];
        logic [4:0]  op;
        logic        valid;
        logic [31:0] rv;

        ops[0] = OP_LW; ops[1] = OP_SW;  ops[2] = OP_BT;     ops[3] = OP_BF; ops[4] = OP_LI;
        ops[5] = OP_LUI; ops[6] = OP_EBREAK; ops[7] = 5'd3; ops[8] = 5'd10;

        reset = 1'b0; halted = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0;
        in_addr = '0; in_data = '0; mem_bus.mem_ready = 1'b0; mem_bus.mem_rdata = '0;

        // Reset takes effect before any clock edge.
        #2 reset = 1'b1;
        #1;
        check("rst_req", mem_bus.mem_req, 1'b0);
        check("rst_we", mem_bus.mem_we, 1'b0);
        check("rst_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("rst_wdata", mem_bus.mem_wdata, 32'd0);
        check("rst_wb_en", wb_en, 1'b0);
        check("rst_wb_rd", wb_rd, 5'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_err", err, 1'b0);
        check("rst_stall", stall, 1'b0);
        @(negedge clk) reset = 1'b0;
        tick();

        // LW addr 0, ready in first request cycle, rdata 74.
        mem_txn(1'b1, 5'd7, '0, 32'hDEAD0000, 1, 32'd74);
        // SW addr 5, data 0x1234, ready after 3 request cycles.
        mem_txn(1'b0, 5'd2, 17'd5, 32'h1234, 3, 32'hFFFF_FFFF);
        // LUI 3 -> 0x00060000.
        alu_txn(1'b1, OP_LUI, 5'd4, 17'h00003, 32'h5555_5555);
        check("lui_const", wb_data, 32'h0006_0000);
        alu_txn(1'b1, OP_LI, 5'd9, 17'h1ABCD, 32'h0);
        alu_txn(1'b0, OP_LW, 5'd1, 17'h1, 32'h1);

        // mem_ready outside BUSY has no effect.
        in_valid = 1'b0;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h7777;
        $display("txn stray_ready");
        tick();
        check("stray_req", mem_bus.mem_req, 1'b0);
        check("stray_wb_en", wb_en, 1'b0);
        tick();
        check("stray_stall", stall, 1'b0);
        mem_bus.mem_ready = 1'b0;

        // Halt for 4 cycles mid-BUSY with mem_ready high.
        in_valid = 1'b1; in_op = OP_LW; in_rd = 5'd3; in_addr = 17'h1AB; in_data = 32'h0;
        $display("txn halt_lw: rd=3 addr=0x1ab");
        #1;
        tick();
        check("halt_req0", mem_bus.mem_req, 1'b1);
        halted = 1'b1;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'hCAFE;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("halt_req", mem_bus.mem_req, 1'b1);
            check("halt_stall", stall, 1'b1);
            check("halt_wb_en", wb_en, 1'b0);
        end
        halted = 1'b0;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("halt_done_wb_en", wb_en, 1'b1);
        check("halt_done_wb_data", wb_data, 32'hCAFE);
        check("halt_done_req", mem_bus.mem_req, 1'b0);
        in_valid = 1'b0;
        tick();
        check("halt_bubble", wb_en, 1'b0);

        // Reset mid-BUSY abandons the access immediately.
        in_valid = 1'b1; in_op = OP_LW; in_rd = 5'd12; in_addr = 17'h42; in_data = 32'h0;
        $display("txn reset_mid_busy");
        #1;
        tick();
        check("rb_req", mem_bus.mem_req, 1'b1);
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("rb_req_clr", mem_bus.mem_req, 1'b0);
        check("rb_addr_clr", 32'(mem_bus.mem_addr), 32'd0);
        check("rb_stall", stall, 1'b0);
        @(negedge clk) reset = 1'b0;
        mem_bus.mem_ready = 1'b1;
        tick();
        mem_bus.mem_ready = 1'b0;
        check("rb_wb_en", wb_en, 1'b0);
        check("rb_req_after", mem_bus.mem_req, 1'b0);

        // Randomized mix of instructions.
        for (int n = 0; n < 30; n++) begin
            op = ops[$urandom_range(0, 8)];
            valid = ($urandom_range(0, 3) != 0);
            rv = $urandom;
            if (valid && (op == OP_LW || op == OP_SW))
                mem_txn(op == OP_LW, 5'($urandom), AW'($urandom), rv, $urandom_range(1, 4), $urandom);
            else
                alu_txn(valid, op, 5'($urandom), AW'($urandom), rv);
        end
        in_valid = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // No acknowledge: abort after 8 BUSY cycles with err set and wb_data 0.
        in_valid = 1'b1; in_op = OP_LW; in_rd = 5'd9; in_addr = 17'h44; in_data = 32'h0;
        mem_bus.mem_ready = 1'b0;
        $display("txn timeout_lw: rd=9 addr=0x44");
        #1;
        tick();
        for (int i = 1; i <= 8; i++) begin
            check("to_req", mem_bus.mem_req, 1'b1);
            check("to_err_wait", err, 1'b0);
            tick();
        end
        check("to_req_drop", mem_bus.mem_req, 1'b0);
        check("to_err", err, 1'b1);
        check("to_wb_en", wb_en, 1'b1);
        check("to_wb_data", wb_data, 32'd0);
        check("to_stall", stall, 1'b0);
        in_valid = 1'b0;
        tick();
        check("to_err_sticky", err, 1'b1);
        check("to_bubble", wb_en, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("to_err_reset", err, 1'b0);
        @(negedge clk) reset = 1'b0;
        tick();
`else
        // Without the timer a long wait simply completes.
        mem_txn(1'b1, 5'd9, 17'h44, 32'h0, 20, 32'h0BAD_F00D);
        check("no_to_err", err, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
